// File: rtl/j1_io_uart.sv
// j1_io_uart: memory-mapped UART for the j1 IO bus.
// The window holds DATA (+0), STATUS (+2), DIV (+4) and a reserved word (+6).
// The block has a 16-deep TX FIFO and a single RX holding register.
// Read data is combinational and reads 0 when the block is not addressed,
// so the read buses of several instances can be ORed together.
module j1_io_uart #(
  parameter logic [15:0] BASE_ADDR     = 16'h4000,
  parameter logic [15:0] CLK_DIV_RESET = 16'd434,
  parameter int          FIFO_AW       = 4
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd_i,
  input  logic        io_wr_i,
  input  logic [15:0] io_addr_i,
  input  logic [15:0] io_data_i,
  output logic [15:0] io_data_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Address decode. Byte address bit 0 does not take part in the decode.
  logic       hit;
  logic [1:0] sel;
  logic       wr_data, wr_stat, wr_div, rd_data;
  assign hit     = (io_addr_i[15:3] == BASE_ADDR[15:3]);
  assign sel     = io_addr_i[2:1];
  assign wr_data = io_wr_i & hit & (sel == 2'd0);
  assign wr_stat = io_wr_i & hit & (sel == 2'd1);
  assign wr_div  = io_wr_i & hit & (sel == 2'd2);
  assign rd_data = io_rd_i & hit & (sel == 2'd0);

  logic [15:0] div_q, per;
  assign per = (div_q < 16'd2) ? 16'd2 : div_q;

  // ---------------- TX FIFO ----------------
  logic [7:0]       mem [2**FIFO_AW];
  logic [FIFO_AW:0] wp, rp;
  logic             empty, full, pop, push;
  assign empty = (wp == rp);
  assign full  = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign push  = wr_data & (~full | pop);

  // FIFO pointers. A push into a full FIFO is accepted only when a pop
  // frees a slot in the same cycle.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // FIFO storage. It needs no reset because the pointers gate every read.
  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wp[FIFO_AW-1:0]] <= io_data_i[7:0];
  end

  // ---------------- TX engine ----------------
  state_t      tx_st, tx_st_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic        tx_q, tx_d;

  // TX state, shifter and the registered line output.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_sh  <= '0;
      tx_bit <= '0;
      tx_q   <= 1'b1;
    end else begin
      tx_st  <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_sh  <= tx_sh_n;
      tx_bit <= tx_bit_n;
      tx_q   <= tx_d;
    end
  end

  // TX next state. The bit counter reloads from DIV at every bit boundary,
  // so a new DIV value takes effect at the next boundary.
  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt;
    tx_sh_n  = tx_sh;
    tx_bit_n = tx_bit;
    pop      = 1'b0;
    case (tx_st)
      S_IDLE: if (!empty) begin
        pop      = 1'b1;
        tx_sh_n  = mem[rp[FIFO_AW-1:0]];
        tx_cnt_n = per - 16'd1;
        tx_st_n  = S_START;
      end
      S_START: if (tx_cnt == 16'd0) begin
        tx_cnt_n = per - 16'd1;
        tx_bit_n = 3'd0;
        tx_st_n  = S_DATA;
      end else tx_cnt_n = tx_cnt - 16'd1;
      S_DATA: if (tx_cnt == 16'd0) begin
        tx_cnt_n = per - 16'd1;
        if (tx_bit == 3'd7) tx_st_n = S_STOP;
        else begin
          tx_bit_n = tx_bit + 3'd1;
          tx_sh_n  = tx_sh >> 1;
        end
      end else tx_cnt_n = tx_cnt - 16'd1;
      S_STOP: if (tx_cnt == 16'd0) tx_st_n = S_IDLE;
              else tx_cnt_n = tx_cnt - 16'd1;
      default: tx_st_n = S_IDLE;
    endcase
    case (tx_st_n)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_sh_n[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign uart_tx_o = tx_q;

  // ---------------- RX engine ----------------
  logic        rx_ff1, rx_s, rx_prev;
  state_t      rx_st, rx_st_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic        done_ok, done_err;

  // Two-flop synchronizer, a delayed copy for edge detection, and RX state.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_ff1  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= S_IDLE;
      rx_cnt  <= '0;
      rx_sh   <= '0;
      rx_bit  <= '0;
    end else begin
      rx_ff1  <= uart_rx_i;
      rx_s    <= rx_ff1;
      rx_prev <= rx_s;
      rx_st   <= rx_st_n;
      rx_cnt  <= rx_cnt_n;
      rx_sh   <= rx_sh_n;
      rx_bit  <= rx_bit_n;
    end
  end

  // RX next state. The start bit is checked at half a bit period, and every
  // later sample falls one full period after the previous one, in mid-bit.
  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt;
    rx_sh_n  = rx_sh;
    rx_bit_n = rx_bit;
    done_ok  = 1'b0;
    done_err = 1'b0;
    case (rx_st)
      S_IDLE: if (rx_prev && !rx_s) begin
        rx_cnt_n = (per >> 1) - 16'd1;
        rx_st_n  = S_START;
      end
      S_START: if (rx_cnt == 16'd0) begin
        if (rx_s) rx_st_n = S_IDLE;
        else begin
          rx_cnt_n = per - 16'd1;
          rx_bit_n = 3'd0;
          rx_st_n  = S_DATA;
        end
      end else rx_cnt_n = rx_cnt - 16'd1;
      S_DATA: if (rx_cnt == 16'd0) begin
        rx_sh_n  = {rx_s, rx_sh[7:1]};
        rx_cnt_n = per - 16'd1;
        if (rx_bit == 3'd7) rx_st_n = S_STOP;
        else rx_bit_n = rx_bit + 3'd1;
      end else rx_cnt_n = rx_cnt - 16'd1;
      S_STOP: if (rx_cnt == 16'd0) begin
        rx_st_n  = S_IDLE;
        done_ok  = rx_s;
        done_err = ~rx_s;
      end else rx_cnt_n = rx_cnt - 16'd1;
      default: rx_st_n = S_IDLE;
    endcase
  end

  // ---------------- registers and flags ----------------
  logic [7:0] rx_data;
  logic       rx_valid, rx_ovr, rx_ferr;

  // Software-visible state. A flag being set wins over a write-1 clear in the
  // same cycle, and a completion that coincides with a DATA read is not an overrun.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      div_q    <= CLK_DIV_RESET;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      if (wr_div) div_q <= io_data_i;
      if (done_ok) rx_data <= rx_sh;
      if (done_ok) rx_valid <= 1'b1;
      else if (rd_data) rx_valid <= 1'b0;
      if (done_ok && rx_valid && !rd_data) rx_ovr <= 1'b1;
      else if (wr_stat && io_data_i[4]) rx_ovr <= 1'b0;
      if (done_err) rx_ferr <= 1'b1;
      else if (wr_stat && io_data_i[5]) rx_ferr <= 1'b0;
    end
  end

  // Read mux, gated by address hit only.
  always_comb begin
    io_data_o = 16'h0000;
    if (hit) begin
      case (sel)
        2'd0:    io_data_o = {8'h00, rx_data};
        2'd1:    io_data_o = {10'd0, rx_ferr, rx_ovr, rx_valid, (tx_st != S_IDLE), empty, full};
        2'd2:    io_data_o = div_q;
        default: io_data_o = 16'h0000;
      endcase
    end
  end

endmodule
